// File: rtl/id_ex_issue_ctrl.sv
// id_ex_issue_ctrl: in-order issue controller at the ID->EX boundary.
// A per-register latency scoreboard flags RAW/WAW hazards, and a small FSM
// sequences branch resolution and the flush that follows a taken branch.
// Optional feature macro: SPU_FWD_EN. When it is defined, a source whose
// producer completes next cycle may issue, because its value comes from the
// EX/WB forwarding path.
module id_ex_issue_ctrl #(
  parameter int NUM_REGS     = 128,
  parameter int REG_AW       = 7,
  parameter int LAT_W        = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [3*REG_AW-1:0]   id_src,
  input  logic [2:0]            id_src_used,
  input  logic [REG_AW-1:0]     id_rt,
  input  logic                  id_rt_wr,
  input  logic [LAT_W-1:0]      id_latency,
  input  logic                  id_is_branch,
  input  logic                  br_resolve,
  input  logic                  br_taken,
  output logic                  issue,
  output logic                  stall,
  output logic                  bubble,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FLUSH_INIT = FC_W'(FLUSH_CYCLES - 1);

`ifdef SPU_FWD_EN
  // A producer one cycle from writeback is covered by forwarding.
  localparam logic [LAT_W-1:0] SRC_T = LAT_W'(1);
`else
  // No forwarding: any pending write to a used source blocks issue.
  localparam logic [LAT_W-1:0] SRC_T = LAT_W'(0);
`endif

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [FC_W-1:0]       flush_cnt_q, flush_cnt_d;
  logic [LAT_W-1:0]      cnt_q [NUM_REGS];
  logic [LAT_W-1:0]      cnt_d [NUM_REGS];
  logic [CNT_W-1:0]      stall_cycles_q, stall_cycles_d;
  logic [LAT_W-1:0]      lat_eff;
  logic                  src_hz;
  logic                  waw_hz;
  logic                  hazard;

  // Latency of 0 is treated as 1 so the result is never considered ready at issue.
  always_comb begin
    if (id_latency == LAT_W'(0)) begin
      lat_eff = LAT_W'(1);
    end else begin
      lat_eff = id_latency;
    end
  end

  // RAW check on the used sources and WAW check on the destination.
  always_comb begin
    src_hz = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (id_src_used[k] && (cnt_q[id_src[k*REG_AW +: REG_AW]] > SRC_T)) begin
        src_hz = 1'b1;
      end else begin
        src_hz = src_hz;
      end
    end
    waw_hz = id_rt_wr && (cnt_q[id_rt] > lat_eff);
    hazard = src_hz | waw_hz;
  end

  // Scoreboard next state: count down, and a new issue load wins over the decrement.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (issue && id_rt_wr && (id_rt == REG_AW'(i))) begin
        cnt_d[i] = lat_eff;
      end else if (cnt_q[i] != LAT_W'(0)) begin
        cnt_d[i] = cnt_q[i] - LAT_W'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        cnt_q[i] <= LAT_W'(0);
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // FSM state and flush counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      flush_cnt_q <= FC_W'(0);
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // FSM next state: wait for branch resolution, then flush the wrong path if taken.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RUN: begin
        if (issue && id_is_branch) begin
          state_d = BR_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      BR_WAIT: begin
        if (br_resolve && br_taken) begin
          state_d     = FLUSH;
          flush_cnt_d = FLUSH_INIT;
        end else if (br_resolve) begin
          state_d = RUN;
        end else begin
          state_d = BR_WAIT;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FC_W'(0)) begin
          state_d = RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - FC_W'(1);
        end
      end
      default: begin
        state_d     = RUN;
        flush_cnt_d = FC_W'(0);
      end
    endcase
  end

  // FSM outputs: decisions are made in the same cycle from registered state.
  always_comb begin
    issue  = 1'b0;
    stall  = 1'b0;
    bubble = 1'b1;
    case (state_q)
      RUN: begin
        issue  = id_valid & ~hazard;
        stall  = id_valid & hazard;
        bubble = ~issue;
      end
      BR_WAIT: begin
        issue  = 1'b0;
        stall  = id_valid;
        bubble = 1'b1;
      end
      FLUSH: begin
        // Wrong-path decode content is dropped, so nothing is held.
        issue  = 1'b0;
        stall  = 1'b0;
        bubble = 1'b1;
      end
      default: begin
        issue  = 1'b0;
        stall  = 1'b0;
        bubble = 1'b1;
      end
    endcase
  end

  // Saturating stall counter next state.
  always_comb begin
    if (stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= CNT_W'(0);
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_id_ex_issue_ctrl.sv
// Testbench for id_ex_issue_ctrl: table of branch-sequencing vectors,
// hand-written scoreboard sequences, and a randomized run against a
// completion-time reference model.
module tb_id_ex_issue_ctrl;
  localparam int AW = 7;
  localparam int LW = 3;
  localparam int FC = 2;
  localparam int CW = 16;
`ifdef SPU_FWD_EN
  localparam int T_EXP = 1;
`else
  localparam int T_EXP = 0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            id_valid;
  logic [3*AW-1:0] id_src;
  logic [2:0]      id_src_used;
  logic [AW-1:0]   id_rt;
  logic            id_rt_wr;
  logic [LW-1:0]   id_latency;
  logic            id_is_branch;
  logic            br_resolve;
  logic            br_taken;
  logic            issue;
  logic            stall;
  logic            bubble;
  logic [CW-1:0]   stall_cycles;

  id_ex_issue_ctrl #(
    .NUM_REGS(128), .REG_AW(AW), .LAT_W(LW), .FLUSH_CYCLES(FC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_rt(id_rt), .id_rt_wr(id_rt_wr),
    .id_latency(id_latency), .id_is_branch(id_is_branch),
    .br_resolve(br_resolve), .br_taken(br_taken), .issue(issue),
    .stall(stall), .bubble(bubble), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [AW-1:0] ra, input logic [2:0] used,
                        input logic [AW-1:0] rt, input logic wr, input logic [LW-1:0] lat,
                        input logic br, input logic res, input logic tk, input logic rst);
    id_valid     = v;
    id_src       = {7'd0, 7'd0, ra};
    id_src_used  = used;
    id_rt        = rt;
    id_rt_wr     = wr;
    id_latency   = lat;
    id_is_branch = br;
    br_resolve   = res;
    br_taken     = tk;
    reset        = rst;
  endtask

  task automatic idle();
    set_in(1'b0, 7'd0, 3'b000, 7'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    set_in(1'b0, 7'd0, 3'b000, 7'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    next_cyc();
    reset = 1'b0;
  endtask

  // Present the current inputs until issue rises; count stalled cycles on the way.
  task automatic wait_issue(input string name, input int exp_stalls);
    int  n;
    logic done;
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (issue) begin
        done = 1'b1;
      end else begin
        if (stall) n++;
        next_cyc();
      end
    end
    chk({name, ".issued"}, done, 1);
    chk({name, ".stalls"}, n, exp_stalls);
    if (done) next_cyc();
  endtask

  typedef struct {
    logic v, br, res, tk, rst;
    logic ei, es, eb;
    int   esc;
  } vec_t;
  vec_t tbl [16];

  // Reference model: per-register completion time, branch pending flag, flush cycles left.
  longint done_at [128];
  longint cyc;
  bit     br_pending;
  int     flush_left;
  int     sc;

  function automatic int mcnt(input int r);
    return (done_at[r] > cyc) ? int'(done_at[r] - cyc) : 0;
  endfunction

  initial begin
    idle();
    reset = 1'b1;
    next_cyc();
    next_cyc();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst.issue", issue, 0); chk("rst.stall", stall, 0);
    chk("rst.bubble", bubble, 1); chk("rst.stall_cycles", stall_cycles, 0);
    next_cyc();

    // Branch sequencing table: {v, br, res, tk, rst, issue, stall, bubble, stall_cycles}
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].v, 7'd0, 3'b000, 7'd0, 1'b0, 3'd1, tbl[i].br, tbl[i].res, tbl[i].tk, tbl[i].rst);
      @(negedge clk);
      chk($sformatf("tbl%0d.issue", i), issue, tbl[i].ei);
      chk($sformatf("tbl%0d.stall", i), stall, tbl[i].es);
      chk($sformatf("tbl%0d.bubble", i), bubble, tbl[i].eb);
      chk($sformatf("tbl%0d.stall_cycles", i), stall_cycles, tbl[i].esc);
      next_cyc();
    end

    // RAW: rt=5 latency 4, then ra=5 right behind it
    do_reset();
    set_in(1'b1, 7'd0, 3'b000, 7'd5, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cyc();
    set_in(1'b1, 7'd5, 3'b001, 7'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_issue("raw", 4 - T_EXP);
    idle();
    @(negedge clk);
    chk("raw.stall_cycles", stall_cycles, 4 - T_EXP);
    next_cyc();

    // Latency 0 behaves as latency 1
    do_reset();
    set_in(1'b1, 7'd0, 3'b000, 7'd4, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cyc();
    set_in(1'b1, 7'd4, 3'b001, 7'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_issue("lat0", 1 - T_EXP);

    // WAW: rt=9 latency 7 in flight, new rt=9 latency 2 waits until cnt<=2
    do_reset();
    set_in(1'b1, 7'd0, 3'b000, 7'd9, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cyc();
    idle();
    next_cyc();
    set_in(1'b1, 7'd0, 3'b000, 7'd9, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_issue("waw", 4);
    set_in(1'b1, 7'd9, 3'b001, 7'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_issue("waw.reload", 2 - T_EXP);

    // Load on the same edge that cnt[3] decrements from 1 wins
    do_reset();
    set_in(1'b1, 7'd0, 3'b000, 7'd3, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cyc();
    set_in(1'b1, 7'd0, 3'b000, 7'd3, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("load_wins.issue", issue, 1);
    next_cyc();
    set_in(1'b1, 7'd3, 3'b001, 7'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_issue("load_wins", 5 - T_EXP);

    // Reset in BR_WAIT with rt=7 pending
    do_reset();
    set_in(1'b1, 7'd0, 3'b000, 7'd7, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cyc();
    set_in(1'b1, 7'd0, 3'b000, 7'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    next_cyc();
    set_in(1'b1, 7'd7, 3'b001, 7'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("rst_brwait.stall_before", stall, 1);
    next_cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_brwait.issue", issue, 1);
    chk("rst_brwait.stall", stall, 0);
    chk("rst_brwait.bubble", bubble, 0);
    chk("rst_brwait.stall_cycles", stall_cycles, 0);
    next_cyc();

    // Randomized run against the reference model
    do_reset();
    cyc = 0;
    for (int r = 0; r < 128; r++) done_at[r] = 0;
    br_pending = 1'b0;
    flush_left = 0;
    sc = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] s0, s1, s2, rt;
      int eff, hz, ei, es, eb;
      bit narrow;
      narrow = ($urandom_range(0, 7) != 0);
      s0 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 127));
      s1 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 127));
      s2 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 127));
      rt = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 127));
      id_valid     = ($urandom_range(0, 4) != 0);
      id_src       = {s2, s1, s0};
      id_src_used  = 3'($urandom_range(0, 7));
      id_rt        = rt;
      id_rt_wr     = ($urandom_range(0, 2) != 0);
      id_latency   = 3'($urandom_range(0, 7));
      id_is_branch = ($urandom_range(0, 9) == 0);
      br_resolve   = ($urandom_range(0, 3) == 0);
      br_taken     = 1'($urandom_range(0, 1));
      reset        = ($urandom_range(0, 59) == 0);

      eff = (id_latency == 0) ? 1 : int'(id_latency);
      hz = 0;
      if (id_src_used[0] && mcnt(int'(s0)) > T_EXP) hz = 1;
      if (id_src_used[1] && mcnt(int'(s1)) > T_EXP) hz = 1;
      if (id_src_used[2] && mcnt(int'(s2)) > T_EXP) hz = 1;
      if (id_rt_wr && mcnt(int'(rt)) > eff) hz = 1;
      if (flush_left > 0) begin
        ei = 0; es = 0; eb = 1;
      end else if (br_pending) begin
        ei = 0; es = int'(id_valid); eb = 1;
      end else begin
        ei = (id_valid && !hz) ? 1 : 0;
        es = (id_valid && hz) ? 1 : 0;
        eb = 1 - ei;
      end

      @(negedge clk);
      chk($sformatf("rnd%0d.issue", n), issue, ei);
      chk($sformatf("rnd%0d.stall", n), stall, es);
      chk($sformatf("rnd%0d.bubble", n), bubble, eb);
      chk($sformatf("rnd%0d.stall_cycles", n), stall_cycles, sc);

      if (reset) begin
        for (int r = 0; r < 128; r++) done_at[r] = 0;
        br_pending = 1'b0;
        flush_left = 0;
        sc = 0;
      end else begin
        if (es != 0 && sc != 65535) sc++;
        if (ei != 0 && id_rt_wr) done_at[rt] = cyc + 1 + eff;
        if (flush_left > 0) begin
          flush_left--;
        end else if (br_pending) begin
          if (br_resolve) begin
            br_pending = 1'b0;
            if (br_taken) flush_left = FC;
          end
        end else if (ei != 0 && id_is_branch) begin
          br_pending = 1'b1;
        end
      end
      cyc++;
      next_cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
